// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   - lsu_state_e   : FSM state encoding
//   - F3_*          : RV32I load/store funct3 codes
//   - lsu_misaligned: access crosses its natural alignment
//   - lsu_legal     : funct3 is a supported load/store width
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1,
        ST_CAPTURE,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Halfword needs ea[0]==0, word needs ea[1:0]==0; bytes are always aligned.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bundle between execute stage and LSU.
//   master (execute): drives req_valid/req_store/req_funct3/rs1/imm/store_data
//   slave  (LSU)    : drives req_ready/resp_valid/resp_data/resp_err
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_store, req_funct3, rs1, imm, store_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_store, req_funct3, rs1, imm, store_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering.
//   off/funct3 : byte offset and width code of the access
//   widx       : 0 = first word of the access, 1 = the following word
//   sdata      : right-aligned store value -> be/wdata for word widx
//   lo/hi_word : read words (hi only matters when the access spans two)
//   ldata      : extracted and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic        widx,
    input  logic [31:0] sdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [3:0]  size_be;
    logic [31:0] size_mask;
    logic [7:0]  be2;
    logic [63:0] wd2;
    logic [31:0] raw;

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            default: size_be = 4'b1111;
        endcase
        size_mask = {{8{size_be[3]}}, {8{size_be[2]}}, {8{size_be[1]}}, {8{size_be[0]}}};

        // Place the access in an 8-byte window; the upper half spills into word w+1.
        be2   = {4'b0000, size_be} << off;
        wd2   = {32'b0, sdata & size_mask} << {off, 3'b000};
        be    = widx ? be2[7:4]   : be2[3:0];
        wdata = widx ? wd2[63:32] : wd2[31:0];

        raw = 32'({hi_word, lo_word} >> {off, 3'b000});
        case (funct3)
            F3_LB:   ldata = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ldata = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ldata = {24'b0, raw[7:0]};
            F3_LHU:  ldata = {16'b0, raw[15:0]};
            default: ldata = raw;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: execute-stage to word-addressed data RAM bridge.
//   clk/rst   : clock, synchronous active-high reset
//   req       : load_store_unit_if.slave request/response bundle
//   mem_*     : word address, write strobe, byte enables, write data, read data
//               (read data arrives one cycle after the address)
// Build option LSU_MISALIGNED_SPLIT_EN: split misaligned accesses into two
// RAM accesses (words w and w+1); otherwise they complete with resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    lsu_state_e        st_q, nxt;
    logic              accept, in_err, in_mis;
    logic [ADDR_W+1:0] ea;   // only the bits that select word + byte; rest wraps away
    logic              store_q, err_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] word_q;
    logic [31:0]       sd_q, data_q;
    logic              widx, issue;
    logic [31:0]       lo_word, al_wdata, al_ldata;
    logic [3:0]        al_be;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              split_q;
    logic [31:0]       lo_q;
`endif

    assign ea     = req.rs1[ADDR_W+1:0] + req.imm[ADDR_W+1:0];
    assign accept = req.req_valid & req.req_ready;
    assign in_mis = lsu_misaligned(req.req_funct3, ea[1:0]);
`ifdef LSU_MISALIGNED_SPLIT_EN
    assign in_err = !lsu_legal(req.req_store, req.req_funct3);
`else
    assign in_err = !lsu_legal(req.req_store, req.req_funct3) | in_mis;
`endif

    always_comb begin
        nxt = st_q;
        case (st_q)
            ST_IDLE:    if (accept) nxt = in_err ? ST_DONE : ST_ISSUE0;
            ST_ISSUE0: begin
                nxt = store_q ? ST_DONE : ST_CAPTURE;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (split_q) nxt = ST_ISSUE1;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ST_ISSUE1:  nxt = store_q ? ST_DONE : ST_CAPTURE;
`endif
            ST_CAPTURE: nxt = ST_DONE;
            ST_DONE:    nxt = ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b0;
            off_q   <= 2'b0;
            word_q  <= '0;
            sd_q    <= 32'b0;
            data_q  <= 32'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q <= 1'b0;
            lo_q    <= 32'b0;
`endif
        end else begin
            st_q <= nxt;
            if (accept) begin
                store_q <= req.req_store;
                err_q   <= in_err;
                f3_q    <= req.req_funct3;
                off_q   <= ea[1:0];
                word_q  <= ea[ADDR_W+1:2];
                sd_q    <= req.store_data;
                data_q  <= 32'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                split_q <= in_mis & !in_err;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            // Word w is on mem_rdata during ISSUE1; hold it while word w+1 arrives.
            if (st_q == ST_ISSUE1 && !store_q) lo_q <= mem_rdata;
`endif
            if (st_q == ST_CAPTURE) data_q <= al_ldata;
        end
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign widx    = (st_q == ST_ISSUE1);
    assign lo_word = split_q ? lo_q : mem_rdata;
`else
    assign widx    = 1'b0;
    assign lo_word = mem_rdata;
`endif

    lsu_align u_align (
        .off     (off_q),
        .funct3  (f3_q),
        .widx    (widx),
        .sdata   (sd_q),
        .lo_word (lo_word),
        .hi_word (mem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .ldata   (al_ldata)
    );

    assign issue     = (st_q == ST_ISSUE0) || (st_q == ST_ISSUE1);
    assign mem_addr  = issue ? word_q + ADDR_W'(widx) : '0;
    assign mem_we    = issue & store_q & !rst;
    assign mem_be    = (issue & store_q) ? al_be : 4'b0;
    assign mem_wdata = (issue & store_q) ? al_wdata : 32'b0;

    assign req.req_ready  = (st_q == ST_IDLE);
    assign req.resp_valid = (st_q == ST_DONE);
    assign req.resp_data  = (st_q == ST_DONE) ? data_q : 32'b0;
    assign req.resp_err   = (st_q == ST_DONE) & err_q;
endmodule
